// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: streams WIDTH-bit operands LSB-first through one
// full-adder/logic bit slice and assembles result, carry-out and zero flag.
module bit_serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero
);

  // state | meaning
  // IDLE  | waiting for start; a/b/op captured on accept
  // RUN   | one operand bit per clock through the slice
  // DONE  | one-cycle done pulse; result/cout/zero just updated
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sa, sb, acc, acc_nxt;
  logic [2:0]       opr;
  logic             c, c_nxt, s;
  logic             accept, last;
  logic             is_arith;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign is_arith = (opr[2:1] == 2'b00);

  // Shared bit slice; SUB reuses the adder with sb pre-inverted and c=1.
  always_comb begin
    s     = 1'b0;
    c_nxt = c;
    case (opr)
      3'b000, 3'b001: begin
        s     = sa[0] ^ sb[0] ^ c;
        c_nxt = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
      end
      3'b010:  s = sa[0] & sb[0];
      3'b011:  s = sa[0] | sb[0];
      3'b100:  s = sa[0] ^ sb[0];
      3'b101:  s = ~(sa[0] ^ sb[0]);
      3'b110:  s = ~(sa[0] & sb[0]);
      3'b111:  s = ~(sa[0] | sb[0]);
      default: s = 1'b0;
    endcase
    acc_nxt = {s, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      acc    <= '0;
      opr    <= '0;
      cnt    <= '0;
      c      <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      zero   <= 1'b0;
    end else if (accept) begin
      sa  <= a;
      sb  <= (op == 3'b001) ? ~b : b;
      opr <= op;
      cnt <= '0;
      c   <= (op == 3'b001);
      acc <= '0;
    end else if (busy) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      c   <= c_nxt;
      acc <= acc_nxt;
      cnt <= cnt + CW'(1);
      if (last) begin
        result <= acc_nxt;
        cout   <= is_arith ? c_nxt : 1'b0;
        zero   <= (acc_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Directed self-checking bench for bit_serial_alu_ctrl, WIDTH=8 and WIDTH=2.
module tb_bit_serial_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start2;
  logic [2:0] op, op2;
  logic [7:0] a, b;
  logic [1:0] a2, b2;
  logic       busy, done, cout, zero;
  logic [7:0] result;
  logic       busy2, done2, cout2, zero2;
  logic [1:0] result2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bit_serial_alu_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero)
  );

  bit_serial_alu_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .op(op2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .result(result2), .cout(cout2), .zero(zero2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input string tag, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] er, input logic ec, input logic ez);
    int n;
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, 8);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_res"}, result, er);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_zero"}, zero, ez);
    tick();
    chk({tag, "_done_clr"}, done, 0);
  endtask

  initial begin
    int n, cnt_done, t1, t2, t3;
    logic [7:0] seen;
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    op = 3'b000; a = '0; b = '0; op2 = 3'b000; a2 = '0; b2 = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", result, 0);
    chk("rst_cout", cout, 0);
    chk("rst_zero", zero, 0);
    rst_n = 1'b1;
    tick();

    run8("add_ff_01", 3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
    run8("add_7f_01", 3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0);
    run8("sub_5_7",   3'b001, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
    run8("sub_7_5",   3'b001, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0);
    run8("and",       3'b010, 8'h3C, 8'hF0, 8'h30, 1'b0, 1'b0);
    run8("or",        3'b011, 8'h12, 8'h21, 8'h33, 1'b0, 1'b0);
    run8("xor",       3'b100, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0);
    run8("xnor",      3'b101, 8'hA5, 8'h0F, 8'h55, 1'b0, 1'b0);
    run8("nand",      3'b110, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1);
    run8("nor",       3'b111, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1);

    // second start and operand changes during RUN must be ignored
    op = 3'b000; a = 8'h10; b = 8'h20; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; a = 8'h01; b = 8'h01; op = 3'b111;
    tick();
    start = 1'b0; a = 8'hFF; b = 8'hFF;
    cnt_done = 0; seen = 8'h00;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) begin
        cnt_done++;
        seen = result;
      end
    end
    chk("hs_done_cnt", cnt_done, 1);
    chk("hs_res", seen, 8'h30);

    // start held high: done every WIDTH+2 cycles
    op = 3'b000; a = 8'h01; b = 8'h01; start = 1'b1;
    t1 = -1; t2 = -1; t3 = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) begin
        if (t1 < 0) t1 = i;
        else if (t2 < 0) t2 = i;
        else if (t3 < 0) t3 = i;
      end
    end
    start = 1'b0;
    chk("held_period1", t2 - t1, 10);
    chk("held_period2", t3 - t2, 10);
    for (int i = 0; i < 12; i++) tick();
    chk("held_res", result, 8'h02);

    // reset at T4 of an ADD
    op = 3'b000; a = 8'h10; b = 8'h20; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_res", result, 0);
    chk("mid_rst_cout", cout, 0);
    chk("mid_rst_zero", zero, 0);
    cnt_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) cnt_done++;
    end
    chk("mid_rst_no_done", cnt_done, 0);
    run8("add_after_rst", 3'b000, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);

    // start coinciding with reset is dropped
    rst_n = 1'b0; start = 1'b1;
    tick();
    rst_n = 1'b1; start = 1'b0;
    chk("rst_start_busy", busy, 0);
    tick();
    chk("rst_start_busy2", busy, 0);

    // WIDTH=2 instance
    op2 = 3'b000; a2 = 2'd3; b2 = 2'd1; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("w2_busy", busy2, 1);
    n = 0;
    while (!done2 && n < 10) begin
      tick();
      n++;
    end
    chk("w2_lat", n, 2);
    chk("w2_res", result2, 2'd0);
    chk("w2_cout", cout2, 1);
    chk("w2_zero", zero2, 1);
    tick();
    chk("w2_done_clr", done2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_serial_alu_ctrl.md
# bit_serial_alu_ctrl

Sequencer for the 1-bit logic/carry datapath. It accepts a WIDTH-bit operation request and streams operand bits LSB-first through a single full-adder/logic bit slice, one bit per clock. It holds the carry between slices, assembles the result, and reports result, carry-out and zero flag with a start/busy/done handshake. It sits between a request source and the shared bit-slice, so that one slice serves arbitrary-width operands.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  in  1  rising-edge clock, sole clock domain.
- rst_n  in  1  synchronous active-low reset, sampled on clk rising edge.
- start  in  1  request pulse/level; sampled only in IDLE.
- op  in  3  operation code, captured with start.
- a  in  WIDTH  operand A, captured with start.
- b  in  WIDTH  operand B, captured with start.
- busy  out  1  high while bits are being processed (RUN).
- done  out  1  one-cycle pulse, result/cout/zero valid and updated.
- result  out  WIDTH  last completed result; held until next completion.
- cout  out  1  carry-out of ADD/SUB (SUB: 1 = no borrow); 0 for logic ops.
- zero  out  1  1 when result == 0.

## Operation
- Op codes:
  - 000 ADD: a+b.
  - 001 SUB: a+~b+1.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 XNOR.
  - 110 NAND.
  - 111 NOR.
- FSM states IDLE, RUN, DONE.
  - IDLE -> RUN on start=1.
  - RUN -> DONE when bit counter reaches WIDTH-1.
  - DONE -> IDLE unconditionally.
- On accept:
  - Load shift registers sa<=a, sb<=b (SUB loads sb<=~b).
  - Latch op; clear the bit counter.
  - Carry register c<=1 for SUB, else 0.
- Each RUN cycle processes bit 0 of sa/sb.
  - Arithmetic bit: s=sa0^sb0^c; c<=maj(sa0,sb0,c).
  - Logic bit: per op; c unchanged.
  - Then shift sa, sb right by 1; shift s into the MSB of the internal accumulator; counter+1.
- Final RUN cycle:
  - Copy the completed accumulator (including the last bit) to result.
  - cout<=final carry for ADD/SUB, 0 otherwise.
  - zero<=(completed value==0).
  - Assert done.
- result, cout and zero change only on a completion edge. Intermediate bits are never visible on result.
- Inputs a, b and op are ignored outside the accept edge. Changing them mid-operation has no effect.
- start while in RUN or DONE is ignored (not queued).
- Arithmetic is modulo 2^WIDTH; overflow is visible only via cout.

## Timing
- Edge T0: start=1 in IDLE is accepted. busy=1 from T0 until T_WIDTH.
- Edges T1..T_WIDTH process bits 0..WIDTH-1.
- At T_WIDTH:
  - state=DONE, busy=0, done=1.
  - result, cout and zero are updated.
- At T_WIDTH+1: state=IDLE, done=0. start is first sampled again at T_WIDTH+2.
  - Minimum issue period is WIDTH+2 cycles.
  - Start-to-done latency is WIDTH cycles.
- Reset (rst_n=0 at an edge), in any state including mid-RUN:
  - state=IDLE, busy=0, done=0, result=0, cout=0, zero=0.
  - Counter, carry and shift registers are cleared.
  - The aborted operation produces no done pulse.
- start=1 on the same edge as rst_n=0 is ignored; reset wins.
- WIDTH=2 boundary: identical behaviour with a 2-cycle RUN.

## Test plan
- ADD, WIDTH=8, a=0xFF b=0x01, start one cycle -> busy for 8 cycles, done at T8, result=0x00, cout=1, zero=1.
- SUB:
  - a=0x05 b=0x07 -> result=0xFE, cout=0, zero=0.
  - Then a=0x07 b=0x05 -> result=0x02, cout=1.
- Logic ops:
  - XNOR a=0xA5 b=0x0F -> result=0x55, cout=0.
  - NOR a=0xF0 b=0x0F -> result=0x00, zero=1.
  - AND a=0x3C b=0xF0 -> 0x30.
- Handshake:
  - Second start with a=0x01 b=0x01 during RUN of ADD 0x10+0x20 -> ignored, done once with 0x30.
  - Changing a/b mid-RUN does not alter the result.
  - start held high -> done pulses every 10 cycles (WIDTH=8).
- Reset mid-operation: rst_n=0 at T4 of ADD -> next cycle busy=0, done=0, result=0, cout=0, zero=0. No done follows. A new ADD 0x01+0x02 afterwards returns 0x03.
- WIDTH=2 instance: ADD a=3 b=1 -> result=0, cout=1, done at T2.
